// File: rtl/rf_wb_if.sv
// Request/write-back bundle for rf_wb_sequencer; hazard ports present only when
// RF_WB_HAZARD_EN is defined.
interface rf_wb_if #(
  parameter int unsigned WD   = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
);
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_addr;
  logic [WD-1:0]   req_data;
  logic            rf_stall;
  logic            wr_en;
  logic [NREG-1:0] wr_sel;
  logic [WD-1:0]   wr_data;
  logic            busy;
  logic            zero_drop;
`ifdef RF_WB_HAZARD_EN
  logic [AW-1:0]   rd_addr_a;
  logic [AW-1:0]   rd_addr_b;
  logic            hazard_a;
  logic            hazard_b;
`endif

  // Request producer / register-bank side.
  modport master (
    output req_valid, req_addr, req_data, rf_stall,
`ifdef RF_WB_HAZARD_EN
    output rd_addr_a, rd_addr_b,
    input  hazard_a, hazard_b,
`endif
    input  req_ready, wr_en, wr_sel, wr_data, busy, zero_drop
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_addr, req_data, rf_stall,
`ifdef RF_WB_HAZARD_EN
    input  rd_addr_a, rd_addr_b,
    output hazard_a, hazard_b,
`endif
    output req_ready, wr_en, wr_sel, wr_data, busy, zero_drop
  );
endinterface

// File: rtl/rf_wb_sequencer.sv
// Write-back sequencer: buffers (addr,data) requests and issues one registered
// one-hot write per cycle to the register bank. Optional feature: RF_WB_HAZARD_EN.
module rf_wb_sequencer #(
  parameter int unsigned WD    = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic  clk,
  input  logic  reset,
  rf_wb_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_mem_q [DEPTH];
  logic [WD-1:0]   data_mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            wr_en_q, wr_en_d;
  logic [NREG-1:0] wr_sel_q, wr_sel_d;
  logic [WD-1:0]   wr_data_q, wr_data_d;
  logic            busy_q, busy_d;
  logic            zero_drop_q, zero_drop_d;

  logic            full, accept, push, pop;
  logic [AW-1:0]   head_addr;
  logic [WD-1:0]   head_data;

  // Readiness looks only at the current count, so a full FIFO refuses even on a pop cycle.
  assign full   = (count_q == CW'(DEPTH));
  assign accept = bus.req_valid & ~full;
  assign push   = accept & (bus.req_addr != '0);
  assign pop    = (state_q == ISSUE);

  assign bus.req_ready = ~full;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_sel    = wr_sel_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = busy_q;
  assign bus.zero_drop = zero_drop_q;

  always_comb begin
    count_d     = count_q + CW'(push) - CW'(pop);
    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    zero_drop_d = accept & (bus.req_addr == '0);

    // Head after this edge; a push into an otherwise drained FIFO bypasses the array.
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      head_addr = bus.req_addr;
      head_data = bus.req_data;
    end else begin
      head_addr = addr_mem_q[rd_ptr_d];
      head_data = data_mem_q[rd_ptr_d];
    end

    state_d = state_q;
    case (state_q)
      IDLE:  if (push) state_d = bus.rf_stall ? WAIT : ISSUE;
      ISSUE: if (count_d != '0) state_d = bus.rf_stall ? WAIT : ISSUE;
             else               state_d = IDLE;
      WAIT:  if (!bus.rf_stall) state_d = ISSUE;
      default: state_d = IDLE;
    endcase

    wr_en_d   = (state_d == ISSUE);
    wr_sel_d  = wr_en_d ? (NREG'(1) << head_addr) : '0;
    wr_data_d = wr_en_d ? head_data : '0;
    busy_d    = (count_d != '0) | wr_en_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_sel_q    <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      zero_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      wr_en_q     <= wr_en_d;
      wr_sel_q    <= wr_sel_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      zero_drop_q <= zero_drop_d;
    end
  end

  // Entry storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      addr_mem_q[wr_ptr_q] <= bus.req_addr;
      data_mem_q[wr_ptr_q] <= bus.req_data;
    end
  end

`ifdef RF_WB_HAZARD_EN
  logic [DEPTH-1:0] ent_valid;
  logic             hit_a, hit_b;

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = CW'(PW'(PW'(i) - rd_ptr_q)) < count_q;
      if (ent_valid[i] && (addr_mem_q[i] == bus.rd_addr_a)) hit_a = 1'b1;
      if (ent_valid[i] && (addr_mem_q[i] == bus.rd_addr_b)) hit_b = 1'b1;
    end
    if (wr_en_q && wr_sel_q[bus.rd_addr_a]) hit_a = 1'b1;
    if (wr_en_q && wr_sel_q[bus.rd_addr_b]) hit_b = 1'b1;
  end

  assign bus.hazard_a = (bus.rd_addr_a != '0) & hit_a;
  assign bus.hazard_b = (bus.rd_addr_b != '0) & hit_b;
`endif
endmodule
